// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls words from the output side of a fifo and sends each one on TXD as an
//   asynchronous serial frame: start bit, WIDTH data bits LSB first, optional
//   parity bit, STOP_BITS stop bits. A waiting word is picked up in the last stop
//   cycle, so back-to-back frames have no idle gap between them.
//
// Parameters
//   WIDTH      data bits per frame (5..16)
//   CLK_DIV    clocks per serial bit (>= 2)
//   STOP_BITS  stop bits per frame (1 or 2)
//   PARITY     0 = none, 1 = even, 2 = odd
//
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   synchronous reset, active high
//   EN      in   transmit enable, only gates the start of a new frame
//   SI_STB  in   word available from the fifo
//   SI_DAT  in   word to send, valid while SI_STB = 1
//   SI_ACK  out  one-cycle pop pulse, first cycle of the start bit
//   TXD     out  serial line, idle high
//   TX_BSY  out  frame in progress
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, waiting for EN and SI_STB
// S_START  | start bit (low) for CLK_DIV cycles
// S_DATA   | WIDTH data bits, shift register bit 0 on the line
// S_PARITY | parity bit of the captured word (PARITY != 0 only)
// S_STOP   | STOP_BITS stop bits (high); may chain straight into S_START

module fifo_uart_tx #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 868,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SI_STB,
    input  logic [WIDTH-1:0] SI_DAT,
    output logic             SI_ACK,
    output logic             TXD,
    output logic             TX_BSY
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(WIDTH);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_nx;
    logic [BW-1:0]    baud_cnt, baud_nx;
    logic [CW-1:0]    bit_cnt, bit_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             par_bit, par_nx;
    logic             txd_nx, ack_nx, bsy_nx;
    logic             baud_end;
    logic             load;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            TXD      <= 1'b1;
            SI_ACK   <= 1'b0;
            TX_BSY   <= 1'b0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
            par_bit  <= par_nx;
            TXD      <= txd_nx;
            SI_ACK   <= ack_nx;
            TX_BSY   <= bsy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        par_nx   = par_bit;
        txd_nx   = TXD;
        ack_nx   = 1'b0;
        bsy_nx   = TX_BSY;
        load     = 1'b0;
        baud_end = (baud_cnt == BAUD_LAST);

        if (state != S_IDLE) begin
            baud_nx = baud_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                txd_nx = 1'b1;
                bsy_nx = 1'b0;
                if (EN && SI_STB) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_nx = S_DATA;
                    bit_nx   = '0;
                    txd_nx   = shreg[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nx = '0;
                        if (PARITY != 0) begin
                            state_nx = S_PARITY;
                            txd_nx   = par_bit;
                        end else begin
                            state_nx = S_STOP;
                            txd_nx   = 1'b1;
                        end
                    end else begin
                        bit_nx   = bit_cnt + 1'b1;
                        shreg_nx = shreg >> 1;
                        // shreg[1] is the bit that lands in position 0 after the shift
                        txd_nx   = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_nx = S_STOP;
                    bit_nx   = '0;
                    txd_nx   = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        if (EN && SI_STB) begin
                            load = 1'b1;
                        end else begin
                            state_nx = S_IDLE;
                            txd_nx   = 1'b1;
                            bsy_nx   = 1'b0;
                        end
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                txd_nx   = 1'b1;
                bsy_nx   = 1'b0;
            end
        endcase

        // Capture and pop; shared by the idle start and the zero-gap chain from S_STOP.
        // Parity is taken from the word as captured, before any shifting.
        if (load) begin
            shreg_nx = SI_DAT;
            par_nx   = (PARITY == 2) ? ~^SI_DAT : ^SI_DAT;
            ack_nx   = 1'b1;
            txd_nx   = 1'b0;
            bsy_nx   = 1'b1;
            baud_nx  = '0;
            bit_nx   = '0;
            state_nx = S_START;
        end
    end

endmodule
